// File: rtl/frame_sender.sv
// frame_sender: pushes one fixed-length frame of pixel groups to a downstream
// image processor over the AXI write channels (AW, W, B).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start_i; out-of-range ip_sel_i sets err_o
//   S_ADDR | AWVALID held high until the address handshake
//   S_DATA | source stream passed straight through to W, beats counted
//   S_RESP | BREADY high; the response is checked, then done_o pulses
module frame_sender #(
  parameter int IP_AMT           = 1,
  parameter int MST_ID_W         = 3,
  parameter int MST_ID           = 0,
  parameter int DATA_WIDTH       = 256,
  parameter int ADDR_WIDTH       = 32,
  parameter int TRANS_WR_RESP_W  = 2,
  parameter int FRAME_PGROUP_NUM = 1024,
  localparam int IPS_W           = (IP_AMT > 1) ? $clog2(IP_AMT) : 1
) (
  input  logic                       ACLK_i,
  input  logic                       ARESETn_i,
  input  logic                       start_i,
  input  logic [IPS_W-1:0]           ip_sel_i,
  input  logic [DATA_WIDTH-1:0]      src_data_i,
  input  logic                       src_valid_i,
  output logic                       src_ready_o,
  output logic [MST_ID_W-1:0]        m_AWID_o,
  output logic [ADDR_WIDTH-1:0]      m_AWADDR_o,
  output logic                       m_AWVALID_o,
  input  logic                       m_AWREADY_i,
  output logic [DATA_WIDTH-1:0]      m_WDATA_o,
  output logic                       m_WLAST_o,
  output logic                       m_WVALID_o,
  input  logic                       m_WREADY_i,
  input  logic [MST_ID_W-1:0]        m_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0] m_BRESP_i,
  input  logic                       m_BVALID_i,
  output logic                       m_BREADY_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int CNT_W    = $clog2(FRAME_PGROUP_NUM + 1);
  localparam int AW_SHIFT = 27;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(FRAME_PGROUP_NUM - 1);
  localparam logic [MST_ID_W-1:0] MST_ID_L = MST_ID_W'(MST_ID);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IPS_W-1:0]   ip_sel_q, ip_sel_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               sel_ok;
  logic               w_beat;

  // Select is only acted on when it names an existing processor.
  assign sel_ok = (32'(ip_sel_i) < 32'(IP_AMT));
  assign w_beat = m_WVALID_o & m_WREADY_i;

  // Address comes straight from the latched select, so it cannot move while AWVALID is up.
  assign m_AWADDR_o = ADDR_WIDTH'(ip_sel_q) << AW_SHIFT;
  assign m_AWID_o   = MST_ID_L;
  assign done_o     = done_q;
  assign err_o      = err_q;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ip_sel_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ip_sel_q <= ip_sel_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Next-state, beat counter, select latch and sticky error.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ip_sel_d = ip_sel_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (sel_ok) begin
            state_d  = S_ADDR;
            err_d    = 1'b0;
            ip_sel_d = ip_sel_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (m_AWREADY_i) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (w_beat) begin
          if (cnt_q == LAST_CNT) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        if (m_BVALID_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if ((m_BRESP_i != '0) || (m_BID_i != MST_ID_L)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel outputs; W is a zero-latency pass-through of the source while in S_DATA.
  always_comb begin
    m_AWVALID_o = 1'b0;
    m_WVALID_o  = 1'b0;
    m_WDATA_o   = '0;
    m_WLAST_o   = 1'b0;
    src_ready_o = 1'b0;
    m_BREADY_o  = 1'b0;
    busy_o      = (state_q != S_IDLE);
    unique case (state_q)
      S_ADDR: m_AWVALID_o = 1'b1;
      S_DATA: begin
        m_WVALID_o  = src_valid_i;
        m_WDATA_o   = src_data_i;
        m_WLAST_o   = (cnt_q == LAST_CNT);
        src_ready_o = m_WREADY_i;
      end
      S_RESP: m_BREADY_o = 1'b1;
      default: ;
    endcase
  end

endmodule
